// File: rtl/id_stage_pipe_pkg.sv
// id_stage_pipe_pkg: ARM decode constants, condition codes, control bundle layout and decode function
package id_stage_pipe_pkg;
  localparam logic [3:0] EXE_MOV = 4'b0001, EXE_ADD = 4'b0010, EXE_ADC = 4'b0011,
                         EXE_SUB = 4'b0100, EXE_SBC = 4'b0101, EXE_AND = 4'b0110,
                         EXE_ORR = 4'b0111, EXE_EOR = 4'b1000, EXE_MVN = 4'b1001;
  localparam logic [3:0] OP_AND = 4'b0000, OP_EOR = 4'b0001, OP_SUB = 4'b0010, OP_ADD = 4'b0100,
                         OP_ADC = 4'b0101, OP_SBC = 4'b0110, OP_TST = 4'b1000, OP_CMP = 4'b1010,
                         OP_ORR = 4'b1100, OP_MOV = 4'b1101, OP_MVN = 4'b1111;
  localparam logic [1:0] MODE_ALU = 2'b00, MODE_MEM = 2'b01, MODE_BR = 2'b10;
  typedef enum logic [3:0] {
    C_EQ, C_NE, C_CS, C_CC, C_MI, C_PL, C_VS, C_VC,
    C_HI, C_LS, C_GE, C_LT, C_GT, C_LE, C_AL, C_NV
  } cond_e;
  localparam int CTRL_B = 0, CTRL_S = 1, CTRL_WB = 2, CTRL_MW = 3, CTRL_MR = 4, CTRL_CMD = 5;
  function automatic logic [8:0] decode(input logic [1:0] mode, input logic [3:0] op, input logic s);
    logic [8:0] d;
    logic [3:0] cmd;
    d = '0;
    case (op)
      OP_MOV:         cmd = EXE_MOV;
      OP_MVN:         cmd = EXE_MVN;
      OP_ADD:         cmd = EXE_ADD;
      OP_ADC:         cmd = EXE_ADC;
      OP_SUB, OP_CMP: cmd = EXE_SUB;
      OP_SBC:         cmd = EXE_SBC;
      OP_AND, OP_TST: cmd = EXE_AND;
      OP_ORR:         cmd = EXE_ORR;
      OP_EOR:         cmd = EXE_EOR;
      default:        cmd = '0;
    endcase
    // Undefined ALU opcodes decode to an all-zero bundle; memory ops use S as the load bit.
    if (mode == MODE_ALU && cmd != '0) begin
      d[CTRL_CMD +: 4] = cmd;
      d[CTRL_WB]       = op != OP_CMP && op != OP_TST;
      d[CTRL_S]        = s;
    end else if (mode == MODE_MEM) begin
      d[CTRL_CMD +: 4] = EXE_ADD;
      d[CTRL_MR]       = s;
      d[CTRL_MW]       = ~s;
      d[CTRL_WB]       = s;
    end else if (mode == MODE_BR) begin
      d[CTRL_B] = 1'b1;
    end
    return d;
  endfunction
endpackage

// File: rtl/id_stage_pipe_if.sv
// id_stage_pipe_if: IF/ID inputs, writeback/hazard inputs and ID/EXE outputs of the decode stage
interface id_stage_pipe_if #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  parameter int REG_AW = $clog2(NREGS),
  parameter int CTRL_W = 9
);
  logic              valid_in, wb_en, exe_wb_en, mem_wb_en, flush, stall, valid_out, imm_out;
  logic [DATA_W-1:0] pc_in, wb_value, pc_out, rn_val, rm_val;
  logic [31:0]       instr_in;
  logic [3:0]        flags_in, flags_out;
  logic [REG_AW-1:0] wb_dest, exe_dest, mem_dest, dest_out, src1_out, src2_out;
  logic [11:0]       shift_op_out;
  logic [23:0]       imm24_out;
  logic [CTRL_W-1:0] ctrl_out;
  modport master (
    output valid_in, pc_in, instr_in, flags_in, wb_en, wb_dest, wb_value,
           exe_wb_en, exe_dest, mem_wb_en, mem_dest, flush,
    input  stall, valid_out, pc_out, rn_val, rm_val, dest_out, src1_out, src2_out,
           imm_out, shift_op_out, imm24_out, ctrl_out, flags_out
  );
  modport slave (
    input  valid_in, pc_in, instr_in, flags_in, wb_en, wb_dest, wb_value,
           exe_wb_en, exe_dest, mem_wb_en, mem_dest, flush,
    output stall, valid_out, pc_out, rn_val, rm_val, dest_out, src1_out, src2_out,
           imm_out, shift_op_out, imm24_out, ctrl_out, flags_out
  );
endinterface

// File: rtl/id_stage_pipe_regfile.sv
// id_regfile: NREGS x DATA_W register file, two async read ports with write bypass, one write port
module id_regfile #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  parameter int REG_AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [REG_AW-1:0] raddr1_i,
  input  logic [REG_AW-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o
);
  logic [DATA_W-1:0] regs_q [NREGS];
  always_ff @(posedge clk or negedge rst)
    if (!rst)
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    else if (we_i)
      regs_q[waddr_i] <= wdata_i;
  assign rdata1_o = (we_i && waddr_i == raddr1_i) ? wdata_i : regs_q[raddr1_i];
  assign rdata2_o = (we_i && waddr_i == raddr2_i) ? wdata_i : regs_q[raddr2_i];
endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: ARM decode stage with regfile, condition check, hazard stall and ID/EXE register
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  parameter int REG_AW = $clog2(NREGS),
  parameter int CTRL_W = 9
) (
  input logic          clk,
  input logic          rst,
  id_stage_pipe_if.slave bus
);
  localparam int ID_W = 2 + 3 * DATA_W + 3 * REG_AW + 12 + 24 + CTRL_W + 4;
  logic [31:0]       ins;
  logic [1:0]        mode;
  logic [3:0]        op;
  logic [CTRL_W-1:0] ctrl;
  logic              n, z, c, v, mem_w, uses1, uses2, hit1, hit2, cond_pass, hazard, valid_d;
  logic [REG_AW-1:0] src1, src2;
  logic [DATA_W-1:0] rn, rm;
  logic [ID_W-1:0]   id_d, id_q;
  assign ins          = bus.instr_in;
  assign mode         = ins[27:26];
  assign op           = ins[24:21];
  assign {n, z, c, v} = bus.flags_in;
  assign ctrl         = decode(mode, op, ins[20]);
  assign mem_w        = ctrl[CTRL_MW];
  assign src1         = ins[16 +: REG_AW];
  assign src2         = mem_w ? ins[12 +: REG_AW] : ins[0 +: REG_AW];
  assign uses1        = mode != MODE_BR && !(mode == MODE_ALU && (op == OP_MOV || op == OP_MVN));
  assign uses2        = mode != MODE_BR && (!ins[25] || mem_w);
  always_comb begin
    cond_pass = 1'b0;
    case (cond_e'(ins[31:28]))
      C_EQ: cond_pass = z;
      C_NE: cond_pass = ~z;
      C_CS: cond_pass = c;
      C_CC: cond_pass = ~c;
      C_MI: cond_pass = n;
      C_PL: cond_pass = ~n;
      C_VS: cond_pass = v;
      C_VC: cond_pass = ~v;
      C_HI: cond_pass = c & ~z;
      C_LS: cond_pass = ~c | z;
      C_GE: cond_pass = n == v;
      C_LT: cond_pass = n != v;
      C_GT: cond_pass = ~z & (n == v);
      C_LE: cond_pass = z | (n != v);
      C_AL: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end
  // Only the EXE/MEM destination inputs count as RAW sources; a same-cycle writeback is bypassed instead.
  assign hit1      = (bus.exe_wb_en && bus.exe_dest == src1) || (bus.mem_wb_en && bus.mem_dest == src1);
  assign hit2      = (bus.exe_wb_en && bus.exe_dest == src2) || (bus.mem_wb_en && bus.mem_dest == src2);
  assign hazard    = bus.valid_in & cond_pass & ((uses1 & hit1) | (uses2 & hit2));
  assign bus.stall = rst & hazard & ~bus.flush;
  assign valid_d   = bus.valid_in & cond_pass;
  id_regfile #(.DATA_W(DATA_W), .NREGS(NREGS), .REG_AW(REG_AW)) u_rf (
    .clk(clk), .rst(rst), .we_i(bus.wb_en), .waddr_i(bus.wb_dest), .wdata_i(bus.wb_value),
    .raddr1_i(src1), .raddr2_i(src2), .rdata1_o(rn), .rdata2_o(rm)
  );
  assign id_d = (bus.flush | bus.stall) ? '0 :
    {valid_d, bus.pc_in, rn, rm, ins[12 +: REG_AW], src1, src2, ins[25], ins[11:0], ins[23:0],
     {CTRL_W{valid_d}} & ctrl, bus.flags_in};
  always_ff @(posedge clk or negedge rst)
    if (!rst) id_q <= '0;
    else      id_q <= id_d;
  assign {bus.valid_out, bus.pc_out, bus.rn_val, bus.rm_val, bus.dest_out, bus.src1_out, bus.src2_out,
          bus.imm_out, bus.shift_op_out, bus.imm24_out, bus.ctrl_out, bus.flags_out} = id_q;
endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed plus randomized checks of id_stage_pipe against a behavioural model
module tb_id_stage_pipe;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  id_stage_pipe_if #(.DATA_W(32), .NREGS(16), .CTRL_W(9)) bus ();
  id_stage_pipe #(.DATA_W(32), .NREGS(16), .CTRL_W(9)) dut (.clk(clk), .rst(rst), .bus(bus));
  int total = 0;
  int bad = 0;
  logic [31:0] mreg [16];
  logic [3:0] alu_cmd [16] = '{4'd6, 4'd8, 4'd4, 4'd0, 4'd2, 4'd3, 4'd5, 4'd0,
                               4'd6, 4'd0, 4'd4, 4'd0, 4'd7, 4'd1, 4'd0, 4'd9};
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic cond_ok(input logic [3:0] cc, input logic [3:0] f);
    logic nn, zz, cy, vv;
    logic [15:0] t;
    {nn, zz, cy, vv} = f;
    t = {1'b0, 1'b1, zz | (nn ^ vv), ~zz & ~(nn ^ vv), nn ^ vv, ~(nn ^ vv), ~cy | zz, cy & ~zz,
         ~vv, vv, ~nn, nn, ~cy, cy, ~zz, zz};
    return t[cc];
  endfunction
  function automatic logic [8:0] ref_ctrl(input logic [31:0] i);
    logic [3:0] cmd;
    cmd = alu_cmd[i[24:21]];
    if (i[27:26] == 2'd0) return cmd == 4'd0 ? 9'd0 : {cmd, 2'b00, !(i[24:21] == 4'd8 || i[24:21] == 4'd10), i[20], 1'b0};
    if (i[27:26] == 2'd1) return {4'd2, i[20], !i[20], i[20], 2'b00};
    if (i[27:26] == 2'd2) return 9'd1;
    return 9'd0;
  endfunction
  function automatic logic busy(input logic [3:0] r);
    return (bus.exe_wb_en && bus.exe_dest == r) || (bus.mem_wb_en && bus.mem_dest == r);
  endfunction
  function automatic logic [31:0] rd(input logic [3:0] r);
    return (bus.wb_en && bus.wb_dest == r) ? bus.wb_value : mreg[r];
  endfunction
  // One clock: predict from current inputs, check stall, then the registered outputs after the edge.
  task automatic cyc();
    logic [31:0] i, pc, rn, rm;
    logic [3:0] s1, s2, fl;
    logic [8:0] ct;
    logic memw, us1, us2, ok, est, v, kill, we;
    logic [3:0] wd;
    logic [31:0] wv;
    #1;
    i    = bus.instr_in;
    pc   = bus.pc_in;
    fl   = bus.flags_in;
    memw = i[27:26] == 2'd1 && !i[20];
    us1  = i[27:26] != 2'd2 && !(i[27:26] == 2'd0 && (i[24:21] == 4'd13 || i[24:21] == 4'd15));
    us2  = i[27:26] != 2'd2 && (!i[25] || memw);
    s1   = i[19:16];
    s2   = memw ? i[15:12] : i[3:0];
    ok   = cond_ok(i[31:28], fl);
    est  = bus.valid_in && ok && ((us1 && busy(s1)) || (us2 && busy(s2))) && !bus.flush;
    kill = est || bus.flush;
    v    = bus.valid_in && ok && !kill;
    ct   = v ? ref_ctrl(i) : 9'd0;
    rn   = rd(s1);
    rm   = rd(s2);
    we   = bus.wb_en;
    wd   = bus.wb_dest;
    wv   = bus.wb_value;
    chk("stall", bus.stall, est);
    @(posedge clk);
    #1;
    chk("valid", bus.valid_out, v);
    chk("ctrl", bus.ctrl_out, ct);
    chk("pc", bus.pc_out, kill ? 32'd0 : pc);
    chk("rn", bus.rn_val, kill ? 32'd0 : rn);
    chk("rm", bus.rm_val, kill ? 32'd0 : rm);
    chk("dest", bus.dest_out, kill ? 4'd0 : i[15:12]);
    chk("src1", bus.src1_out, kill ? 4'd0 : s1);
    chk("src2", bus.src2_out, kill ? 4'd0 : s2);
    chk("imm", bus.imm_out, kill ? 1'b0 : i[25]);
    chk("shift", bus.shift_op_out, kill ? 12'd0 : i[11:0]);
    chk("imm24", bus.imm24_out, kill ? 24'd0 : i[23:0]);
    chk("flags", bus.flags_out, kill ? 4'd0 : fl);
    if (we) mreg[wd] = wv;
    @(negedge clk);
  endtask
  task automatic idle();
    bus.valid_in = 1'b0; bus.pc_in = '0; bus.instr_in = '0; bus.flags_in = '0;
    bus.wb_en = 1'b0; bus.wb_dest = '0; bus.wb_value = '0; bus.flush = 1'b0;
    bus.exe_wb_en = 1'b0; bus.exe_dest = '0; bus.mem_wb_en = 1'b0; bus.mem_dest = '0;
  endtask
  initial begin
    for (int k = 0; k < 16; k++) mreg[k] = '0;
    idle();
    bus.valid_in = 1'b1; bus.instr_in = 32'hE0821003; bus.exe_wb_en = 1'b1; bus.exe_dest = 4'd2;
    #2;
    chk("rst_stall", bus.stall, 1'b0);
    chk("rst_valid", bus.valid_out, 1'b0);
    chk("rst_ctrl", bus.ctrl_out, 9'd0);
    chk("rst_pc", bus.pc_out, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle();
    bus.wb_en = 1'b1; bus.wb_dest = 4'd2; bus.wb_value = 32'd5;
    cyc();
    bus.wb_dest = 4'd3; bus.wb_value = 32'd7;
    cyc();
    bus.wb_en = 1'b0;
    bus.valid_in = 1'b1; bus.instr_in = 32'hE0821003; bus.pc_in = 32'h100;
    cyc();
    chk("add_valid", bus.valid_out, 1'b1);
    chk("add_rn", bus.rn_val, 32'd5);
    chk("add_rm", bus.rm_val, 32'd7);
    chk("add_dest", bus.dest_out, 4'd1);
    chk("add_wb", bus.ctrl_out[2], 1'b1);
    bus.wb_en = 1'b1; bus.wb_dest = 4'd2; bus.wb_value = 32'h55;
    cyc();
    chk("bypass_rn", bus.rn_val, 32'h55);
    bus.wb_en = 1'b0;
    bus.exe_wb_en = 1'b1; bus.exe_dest = 4'd2;
    #1 chk("raw_stall", bus.stall, 1'b1);
    cyc();
    chk("raw_valid", bus.valid_out, 1'b0);
    chk("raw_ctrl", bus.ctrl_out, 9'd0);
    bus.exe_wb_en = 1'b0;
    #1 chk("raw_release", bus.stall, 1'b0);
    cyc();
    chk("raw_issue", bus.valid_out, 1'b1);
    bus.instr_in = 32'hE3A01004; bus.exe_wb_en = 1'b1; bus.exe_dest = 4'd4;
    #1 chk("mov_imm_stall", bus.stall, 1'b0);
    cyc();
    bus.exe_wb_en = 1'b0;
    bus.instr_in = 32'h00821003; bus.flags_in = 4'b0000;
    cyc();
    chk("eq_z0", bus.valid_out, 1'b0);
    bus.flags_in = 4'b0100;
    cyc();
    chk("eq_z1", bus.valid_out, 1'b1);
    bus.instr_in = 32'hF0821003;
    cyc();
    chk("cond_nv", bus.valid_out, 1'b0);
    bus.instr_in = 32'hE0821003; bus.exe_wb_en = 1'b1; bus.exe_dest = 4'd2; bus.flush = 1'b1;
    #1 chk("flush_stall", bus.stall, 1'b0);
    cyc();
    chk("flush_valid", bus.valid_out, 1'b0);
    for (int k = 0; k < 300; k++) begin
      bus.instr_in  = $urandom;
      if ($urandom_range(0, 2) == 0) bus.instr_in[31:28] = 4'hE;
      bus.valid_in  = $urandom_range(0, 7) != 0;
      bus.pc_in     = $urandom;
      bus.flags_in  = 4'($urandom);
      bus.flush     = $urandom_range(0, 7) == 0;
      bus.wb_en     = $urandom_range(0, 1) == 1;
      bus.wb_dest   = 4'($urandom);
      bus.wb_value  = $urandom;
      bus.exe_wb_en = $urandom_range(0, 2) == 0;
      bus.exe_dest  = 4'($urandom);
      bus.mem_wb_en = $urandom_range(0, 2) == 0;
      bus.mem_dest  = 4'($urandom);
      cyc();
    end
    idle();
    bus.valid_in = 1'b1; bus.instr_in = 32'hE0821003; bus.pc_in = 32'h200;
    bus.wb_en = 1'b1; bus.wb_dest = 4'd2; bus.wb_value = 32'h99;
    cyc();
    bus.wb_en = 1'b0;
    bus.exe_wb_en = 1'b1; bus.exe_dest = 4'd3;
    #1 chk("mid_stall", bus.stall, 1'b1);
    rst = 1'b0;
    #1;
    chk("arst_stall", bus.stall, 1'b0);
    chk("arst_valid", bus.valid_out, 1'b0);
    chk("arst_pc", bus.pc_out, 32'd0);
    chk("arst_rn", bus.rn_val, 32'd0);
    chk("arst_dest", bus.dest_out, 4'd0);
    for (int k = 0; k < 16; k++) mreg[k] = '0;
    @(negedge clk);
    rst = 1'b1;
    bus.exe_wb_en = 1'b0;
    cyc();
    chk("post_rst_rn", bus.rn_val, 32'd0);
    chk("post_rst_valid", bus.valid_out, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
